// File: rtl/chain_driver.sv
// -----------------------------------------------------------------------------
// chain_driver
//
// Purpose:
//   Serialises one DATA_LEN-bit word into an external serial shift-register
//   chain, LSB first. While shifting, it collects the chain's previous contents
//   from chain_return. A single update pulse then commits the new contents,
//   and the collected word is offered downstream on a valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   in_valid      upstream word available
//   in_ready      driver idle and accepting a word
//   in_data       word to load; bit i ends up in chain cell i
//   chain_data    serial bit to the chain's data_in (0 outside SHIFT)
//   chain_enable  one-cycle shift strobe, once every SHIFT_DIV cycles
//   chain_update  one-cycle commit strobe after the last shift
//   chain_return  chain data_out (content of cell 0)
//   out_valid     readback word available
//   out_ready     downstream accepts the readback word
//   out_data      previous chain contents; bit i = former cell i
//   busy          high whenever the driver is not idle
// -----------------------------------------------------------------------------
module chain_driver #(
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned SHIFT_DIV = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                chain_data,
    output logic                chain_enable,
    output logic                chain_update,
    input  logic                chain_return,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic                busy
);

    localparam int unsigned CW = $clog2(DATA_LEN + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [7:0]    DIV_LAST = 8'(SHIFT_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_LEN - 1);

    logic [1:0]          r_state;
    logic [DATA_LEN-1:0] r_tx;
    logic [DATA_LEN-1:0] r_rx;
    logic [CW-1:0]       r_cnt;
    logic [7:0]          r_div;

    logic w_enable;

    // One shift step per SHIFT_DIV cycles: strobe on the last divider count.
    assign w_enable = (r_state == SHIFT) && (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_div   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_tx    <= in_data;
                        r_cnt   <= '0;
                        r_div   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_enable) begin
                        r_div <= '0;
                        r_tx  <= r_tx >> 1;
                        // Cell 0 comes out first, so after DATA_LEN steps the
                        // first returned bit has walked down to rx bit 0.
                        r_rx  <= {chain_return, r_rx[DATA_LEN-1:1]};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= UPDATE;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                UPDATE: begin
                    r_state <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign chain_data   = (r_state == SHIFT) & r_tx[0];
    assign chain_enable = w_enable;
    assign chain_update = (r_state == UPDATE);
    assign out_valid    = (r_state == RESP);
    assign out_data     = r_rx;
    assign busy         = (r_state != IDLE);

endmodule

// File: doc/chain_driver.md
CHAIN_DRIVER -- requirements
Module: chain_driver

Interface
REQ-001 Parameter: DATA_LEN, default 8, width of one chain word and number of chain cells driven.
REQ-002 Parameter: SHIFT_DIV, default 1, clock cycles per chain shift step; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream word available.
REQ-006 Port: in_ready  output  1  driver accepts a word this cycle.
REQ-007 Port: in_data  input  DATA_LEN  word to load into chain; bit i targets chain cell i.
REQ-008 Port: chain_data  output  1  serial bit to shift-register data_in.
REQ-009 Port: chain_enable  output  1  shift-register enable; one-cycle pulse per shift step.
REQ-010 Port: chain_update  output  1  shift-register update; one-cycle pulse after the last shift.
REQ-011 Port: chain_return  input  1  shift-register data_out (cell 0 content).
REQ-012 Port: out_valid  output  1  readback word available.
REQ-013 Port: out_ready  input  1  downstream accepts readback word.
REQ-014 Port: out_data  output  DATA_LEN  previous chain contents; bit i = former cell i.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT, UPDATE, RESP.
REQ-017 IDLE: in_ready=1; on in_valid=1, latch in_data into tx buffer, clear bit counter and divider, go to SHIFT next cycle.
REQ-018 in_ready SHALL be 0 in SHIFT, UPDATE, RESP; no new word accepted until return to IDLE.
REQ-019 SHIFT: chain_data SHALL equal tx buffer bit 0 continuously (LSB first).
REQ-020 SHIFT: divider counts 0..SHIFT_DIV-1; chain_enable=1 only in the cycle where divider equals SHIFT_DIV-1.
REQ-021 On each edge with chain_enable=1: sample chain_return into rx buffer MSB while rx shifts right, shift tx buffer right, increment bit counter.
REQ-022 After the DATA_LEN-th enable pulse, FSM SHALL go to UPDATE; exactly DATA_LEN enable pulses per word.
REQ-023 UPDATE: chain_update=1 for exactly one cycle, chain_enable=0; then go to RESP.
REQ-024 RESP: out_valid=1, out_data=rx buffer, held stable until out_ready=1; on out_valid&out_ready go to IDLE next cycle.
REQ-025 chain_enable and chain_update SHALL never be high in the same cycle.
REQ-026 Latency, SHIFT_DIV=1: accept at edge 0, enables at edges 1..DATA_LEN, update at edge DATA_LEN+1, out_valid from cycle DATA_LEN+2.
REQ-027 General latency to out_valid: DATA_LEN*SHIFT_DIV+2 cycles after acceptance.
REQ-028 out_ready=1 with out_valid=0 SHALL be ignored; in_valid outside IDLE SHALL be ignored, word not lost (in_ready=0).
REQ-029 Bit counter width: clog2(DATA_LEN+1); divider width 8 bits; no wrap within a word.
REQ-030 Outputs outside SHIFT: chain_data=0.

Reset
REQ-031 With reset=0 at a rising edge: state=IDLE, tx/rx buffers, counter, divider=0.
REQ-032 Output values during/after reset: in_ready=1, chain_data=0, chain_enable=0, chain_update=0, out_valid=0, out_data=0, busy=0.
REQ-033 Reset mid-SHIFT or mid-RESP SHALL abort the transfer with no chain_update pulse and discard the pending readback.

Verification
REQ-034 DATA_LEN=8, SHIFT_DIV=1, chain preloaded 0x00, send 0xA5 -> 8 enable pulses, chain_data sequence 1,0,1,0,0,1,0,1, one update pulse, out_data=0x00, chain bit_out=0xA5.
REQ-035 Back-to-back: send 0xA5 then 0x3C -> second readback out_data=0xA5, chain bit_out=0x3C.
REQ-036 SHIFT_DIV=3, send 0xFF -> enable pulses every 3rd cycle, out_valid exactly 26 cycles after acceptance.
REQ-037 Hold out_ready=0 for 10 cycles in RESP -> out_valid and out_data stable, in_ready=0, then one-cycle out_ready returns to IDLE.
REQ-038 Assert reset=0 after 4 enable pulses -> all outputs at reset values next cycle, no chain_update pulse, next word 0x5A completes normally.
REQ-039 Assertion for all tests: chain_enable and chain_update never simultaneously high; enable count per word equals DATA_LEN.
